alu_wb_buffer: RTL and testbench
================================

Name: alu_wb_buffer

Overview:
- Consumer end of the ALU result interface.
- Accepts completed ALU results (result, zero flag, destination register) via valid/ready handshake, buffers them in a small in-order FIFO, and drains one entry per cycle into the register-file write port.
- Provides a youngest-match forwarding lookup on two read addresses so decode can bypass pending writes.
- Sits between EX and the register file.

Parameters:
- DEPTH, 4, number of buffer entries (power of two, >=2)
- XLEN, 32, data width
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous discard of all buffered entries
- in_valid  in  1  ALU result valid
- in_ready  out  1  buffer can accept
- in_result  in  XLEN  ALU result
- in_zero  in  1  ALU zero flag (stored, reported on retire)
- in_rd  in  REG_AW  destination register
- in_we  in  1  result writes a register
- rf_ready  in  1  register-file port granted this cycle
- rf_we  out  1  write strobe
- rf_waddr  out  REG_AW  write address
- rf_wdata  out  XLEN  write data
- rf_zero  out  1  zero flag of retiring entry
- fwd_rs1_addr  in  REG_AW  lookup address 1
- fwd_rs1_hit  out  1  pending write to rs1
- fwd_rs1_data  out  XLEN  youngest pending value for rs1
- fwd_rs2_addr, fwd_rs2_hit, fwd_rs2_data: same as rs1, for lookup 2
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Clock and reset: single clock, clk; reset is asynchronous, active-low, rst_n.
- Reset: pointers=0, count=0, all entry valid bits=0. Consequently in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0, rf_zero=0, hits=0, fwd data=0.
- Push: occurs when in_valid && in_ready, where in_ready = (count != DEPTH).
  - Entries with in_we=0 or in_rd=0 complete the handshake but are not stored (count unchanged).
- Head outputs:
  - rf_we = (count != 0), combinational from the head entry.
  - rf_waddr, rf_wdata, rf_zero = head fields; all zero when empty.
- Pop: rf_we && rf_ready, at the clock edge.
- Latency: result accepted at edge N has rf_we high no earlier than cycle N+1.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - When full, in_ready=0 even if rf_ready=1 (no same-cycle space reuse).
- Pointer wrap: modulo DEPTH; full/empty are derived from count, not from pointer equality.
- Forwarding:
  - Compare the address against all valid entries; hit = any match.
  - Data = the youngest match (closest to tail).
  - Address 0 never hits.
  - The incoming in_* beat is not searched (no same-cycle bypass in base config).
- flush:
  - Next edge clears count, pointers and valid bits.
  - Overrides a push and a pop in the same cycle: neither takes effect, and the rf write shown that cycle is discarded only if rf_ready=0; if rf_ready=1 that write is still performed by the register file.
- Reset mid-operation: all buffered entries are lost; no write strobe is issued during or after reset until a new push.

Optional Feature:
- Macro: ALU_WB_BYPASS_EN.
- Defined:
  - When count==0 and in_valid && in_we && in_rd!=0 && rf_ready && !flush, the incoming beat drives rf_we/rf_waddr/rf_wdata/rf_zero combinationally and is not stored (zero-latency retire).
  - Forwarding also matches the incoming beat with highest priority.
- Undefined: base behaviour, minimum one-cycle latency.

Decomposition:
- Shared defines package holds:
  - XLEN and REG_AW constants
  - wb_entry_t typedef (valid, rd, result, zero)
  - DEPTH default
- One natural sub-module, wb_fwd_lookup:
  - purely combinational youngest-match search over the entry array given the tail pointer
  - instantiated twice (rs1, rs2)

Test Plan:
- Reset then idle: rf_we=0, in_ready=1, count=0 during and after rst_n low; fwd hits=0 for addr 5.
- Push {rd=5, result=0xc01e1043, zero=0} with rf_ready=0: count=1 next cycle; fwd_rs1_addr=5 -> hit=1, data=0xc01e1043; assert rf_ready -> rf_we=1, waddr=5, wdata=0xc01e1043, count=0 after edge.
- Push four results with rf_ready=0: count=4, in_ready=0; fifth beat held; one pop -> in_ready=1, fifth accepted next edge; retire order preserved.
- Push rd=7 values 0x1, then 0x2, then 0x3: fwd on 7 returns 0x3; after two pops it still returns 0x3; after the third pop hit=0.
- Push in_rd=0 result=0xdeadbeef and in_we=0 rd=3: both handshakes complete, count stays 0, no rf_we, fwd on 0/3 no hit.
- Fill 3 entries, assert flush with in_valid=1 and rf_ready=0: count=0 next cycle, new beat dropped, rf_we=0; rst_n pulsed low mid-drain -> outputs return to reset values immediately.

Source files
------------

// File: rtl/alu_wb_buffer_pkg.sv
// Shared definitions for the ALU write-back buffer.
//   WB_XLEN      : default result data width
//   WB_REG_AW    : default register address width
//   WB_DEPTH     : default number of buffer entries
//   wb_entry_t   : layout of one buffered write-back entry
package alu_wb_buffer_pkg;

   localparam int WB_XLEN   = 32;
   localparam int WB_REG_AW = 5;
   localparam int WB_DEPTH  = 4;

   typedef struct packed {
      logic                 valid;
      logic [WB_REG_AW-1:0] rd;
      logic [WB_XLEN-1:0]   result;
      logic                 zero;
   } wb_entry_t;

endpackage

// File: rtl/alu_wb_buffer_fwd_lookup.sv
// wb_fwd_lookup: combinational youngest-match search over the write-back
// buffer entries.
//   valid/rd/result : entry arrays, indexed by slot
//   tail            : next write slot; tail-1 holds the youngest entry
//   addr            : lookup register address (0 never hits)
//   hit/data        : match flag and value of the youngest matching entry
module wb_fwd_lookup #(
   parameter int DEPTH  = 4,
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic                     valid [DEPTH],
   input  logic [REG_AW-1:0]        rd    [DEPTH],
   input  logic [XLEN-1:0]          result[DEPTH],
   input  logic [$clog2(DEPTH)-1:0] tail,
   input  logic [REG_AW-1:0]        addr,
   output logic                     hit,
   output logic [XLEN-1:0]          data
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0] idx;

   // Walk slots from tail (oldest possible) round to tail-1 (youngest);
   // later matches overwrite earlier ones so the youngest wins. Empty slots
   // always have valid=0, so a full or partial ring is handled uniformly.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      if (addr != '0) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = tail + AW'(k);
            if (valid[idx] && (rd[idx] == addr)) begin
               hit  = 1'b1;
               data = result[idx];
            end
         end
      end
   end

endmodule

// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: in-order write-back buffer between EX and the register file.
//   clk, rst_n (async, active-low), flush (sync discard of all entries)
//   in_*       : ALU result beat, valid/ready handshake
//   rf_*       : register-file write port, head entry retires on rf_ready
//   fwd_rs*    : youngest-match forwarding lookups over pending writes
//   count      : buffer occupancy
// Optional feature macro ALU_WB_BYPASS_EN: zero-latency retire of an incoming
// beat when the buffer is empty, and forwarding from the incoming beat.
module alu_wb_buffer
   import alu_wb_buffer_pkg::*;
#(
   parameter int DEPTH  = WB_DEPTH,
   parameter int XLEN   = WB_XLEN,
   parameter int REG_AW = WB_REG_AW
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_result,
   input  logic                     in_zero,
   input  logic [REG_AW-1:0]        in_rd,
   input  logic                     in_we,
   input  logic                     rf_ready,
   output logic                     rf_we,
   output logic [REG_AW-1:0]        rf_waddr,
   output logic [XLEN-1:0]          rf_wdata,
   output logic                     rf_zero,
   input  logic [REG_AW-1:0]        fwd_rs1_addr,
   output logic                     fwd_rs1_hit,
   output logic [XLEN-1:0]          fwd_rs1_data,
   input  logic [REG_AW-1:0]        fwd_rs2_addr,
   output logic                     fwd_rs2_hit,
   output logic [XLEN-1:0]          fwd_rs2_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic              e_valid [DEPTH];
   logic [REG_AW-1:0] e_rd    [DEPTH];
   logic [XLEN-1:0]   e_result[DEPTH];
   logic              e_zero  [DEPTH];

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic          not_empty;
   logic          beat_wr;
   logic          bypass;
   logic          store;
   logic          pop;
   logic          lk1_hit, lk2_hit;
   logic [XLEN-1:0] lk1_data, lk2_data;

   assign in_ready  = (count != CW'(DEPTH));
   assign not_empty = (count != '0);
   assign beat_wr   = in_valid && in_we && (in_rd != '0);

`ifdef ALU_WB_BYPASS_EN
   assign bypass = !not_empty && beat_wr && rf_ready && !flush;
`else
   assign bypass = 1'b0;
`endif

   assign store = beat_wr && in_ready && !bypass;
   assign pop   = not_empty && rf_ready;

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      rf_zero  = 1'b0;
      if (not_empty) begin
         rf_we    = 1'b1;
         rf_waddr = e_rd[head];
         rf_wdata = e_result[head];
         rf_zero  = e_zero[head];
      end else if (bypass) begin
         rf_we    = 1'b1;
         rf_waddr = in_rd;
         rf_wdata = in_result;
         rf_zero  = in_zero;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            e_valid[i]  <= 1'b0;
            e_rd[i]     <= '0;
            e_result[i] <= '0;
            e_zero[i]   <= 1'b0;
         end
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            e_valid[i] <= 1'b0;
         end
      end else begin
         // store and pop never target the same slot: tail==head only when
         // empty (no pop) or full (no store).
         if (store) begin
            e_valid[tail]  <= 1'b1;
            e_rd[tail]     <= in_rd;
            e_result[tail] <= in_result;
            e_zero[tail]   <= in_zero;
            tail           <= tail + 1'b1;
         end
         if (pop) begin
            e_valid[head] <= 1'b0;
            head          <= head + 1'b1;
         end
         if (store && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !store) begin
            count <= count - 1'b1;
         end
      end
   end

   wb_fwd_lookup #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
      .valid (e_valid),
      .rd    (e_rd),
      .result(e_result),
      .tail  (tail),
      .addr  (fwd_rs1_addr),
      .hit   (lk1_hit),
      .data  (lk1_data)
   );

   wb_fwd_lookup #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
      .valid (e_valid),
      .rd    (e_rd),
      .result(e_result),
      .tail  (tail),
      .addr  (fwd_rs2_addr),
      .hit   (lk2_hit),
      .data  (lk2_data)
   );

`ifdef ALU_WB_BYPASS_EN
   // The incoming beat is younger than anything buffered, so it takes priority.
   always_comb begin
      fwd_rs1_hit  = lk1_hit;
      fwd_rs1_data = lk1_data;
      fwd_rs2_hit  = lk2_hit;
      fwd_rs2_data = lk2_data;
      if (beat_wr && (in_rd == fwd_rs1_addr)) begin
         fwd_rs1_hit  = 1'b1;
         fwd_rs1_data = in_result;
      end
      if (beat_wr && (in_rd == fwd_rs2_addr)) begin
         fwd_rs2_hit  = 1'b1;
         fwd_rs2_data = in_result;
      end
   end
`else
   assign fwd_rs1_hit  = lk1_hit;
   assign fwd_rs1_data = lk1_data;
   assign fwd_rs2_hit  = lk2_hit;
   assign fwd_rs2_data = lk2_data;
`endif

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Self-checking bench for alu_wb_buffer (default build) against a queue-based
// reference model: directed scenarios followed by a randomized run.
module tb_alu_wb_buffer;

   localparam int DEPTH  = 4;
   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [XLEN-1:0]   in_result;
   logic              in_zero;
   logic [REG_AW-1:0] in_rd;
   logic              in_we;
   logic              rf_ready;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [XLEN-1:0]   rf_wdata;
   logic              rf_zero;
   logic [REG_AW-1:0] fwd_rs1_addr;
   logic              fwd_rs1_hit;
   logic [XLEN-1:0]   fwd_rs1_data;
   logic [REG_AW-1:0] fwd_rs2_addr;
   logic              fwd_rs2_hit;
   logic [XLEN-1:0]   fwd_rs2_data;
   logic [$clog2(DEPTH):0] count;

   alu_wb_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .REG_AW(REG_AW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_zero(in_zero), .in_rd(in_rd), .in_we(in_we),
      .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .rf_zero(rf_zero),
      .fwd_rs1_addr(fwd_rs1_addr), .fwd_rs1_hit(fwd_rs1_hit),
      .fwd_rs1_data(fwd_rs1_data),
      .fwd_rs2_addr(fwd_rs2_addr), .fwd_rs2_hit(fwd_rs2_hit),
      .fwd_rs2_data(fwd_rs2_data),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   res;
      logic              z;
   } ent_t;

   ent_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fwd_model(input logic [REG_AW-1:0] a, output logic hit, output logic [XLEN-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (a != 0) begin
         for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].rd == a) begin
               hit = 1'b1;
               d   = q[i].res;
               break;
            end
         end
      end
   endtask

   task automatic check_outputs();
      logic h1, h2;
      logic [XLEN-1:0] d1, d2;
      fwd_model(fwd_rs1_addr, h1, d1);
      fwd_model(fwd_rs2_addr, h2, d2);
      chk("count",    64'(count),    64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
      chk("rf_we",    64'(rf_we),    64'(q.size() != 0));
      chk("rf_waddr", 64'(rf_waddr), (q.size() != 0) ? 64'(q[0].rd)  : 64'h0);
      chk("rf_wdata", 64'(rf_wdata), (q.size() != 0) ? 64'(q[0].res) : 64'h0);
      chk("rf_zero",  64'(rf_zero),  (q.size() != 0) ? 64'(q[0].z)   : 64'h0);
      chk("rs1_hit",  64'(fwd_rs1_hit),  64'(h1));
      chk("rs1_data", 64'(fwd_rs1_data), 64'(d1));
      chk("rs2_hit",  64'(fwd_rs2_hit),  64'(h2));
      chk("rs2_data", 64'(fwd_rs2_data), 64'(d2));
   endtask

   // Called at a negedge with inputs already set: check, take the edge,
   // advance the model with the inputs that were live at that edge.
   task automatic step();
      logic push, pop;
      #1 check_outputs();
      @(posedge clk);
      if (flush) begin
         q.delete();
      end else begin
         push = in_valid && (q.size() != DEPTH) && in_we && (in_rd != 0);
         pop  = (q.size() != 0) && rf_ready;
         if (pop) void'(q.pop_front());
         if (push) q.push_back('{rd: in_rd, res: in_result, z: in_zero});
      end
      @(negedge clk);
   endtask

   task automatic beat(input logic v, input logic [REG_AW-1:0] rd,
                       input logic [XLEN-1:0] res, input logic z, input logic we);
      in_valid  = v;
      in_rd     = rd;
      in_result = res;
      in_zero   = z;
      in_we     = we;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; rf_ready = 1'b0;
      beat(1'b0, '0, '0, 1'b0, 1'b0);
      fwd_rs1_addr = 5; fwd_rs2_addr = 5;

      // Reset and idle
      @(negedge clk);
      #1 check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();

      // Single push, forward, retire
      beat(1'b1, 5, 32'hc01e1043, 1'b0, 1'b1);
      step();
      beat(1'b0, '0, '0, 1'b0, 1'b0);
      #1 chk("plan_fwd_data", 64'(fwd_rs1_data), 64'hc01e1043);
      step();
      rf_ready = 1'b1;
      #1 chk("plan_rf_wdata", 64'(rf_wdata), 64'hc01e1043);
      step();
      rf_ready = 1'b0;
      step();

      // Fill, hold fifth beat, single pop, ordered drain
      fwd_rs1_addr = 2; fwd_rs2_addr = 4;
      for (int i = 1; i <= 4; i++) begin
         beat(1'b1, REG_AW'(i), 32'h100 + 32'(i), i[0], 1'b1);
         step();
      end
      beat(1'b1, 6, 32'h600, 1'b1, 1'b1);
      step();
      step();
      rf_ready = 1'b1;
      step();
      rf_ready = 1'b0;
      step();
      beat(1'b0, '0, '0, 1'b0, 1'b0);
      rf_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();
      rf_ready = 1'b0;

      // Youngest-match on repeated destination
      fwd_rs1_addr = 7; fwd_rs2_addr = 7;
      for (int i = 1; i <= 3; i++) begin
         beat(1'b1, 7, 32'(i), 1'b0, 1'b1);
         step();
      end
      beat(1'b0, '0, '0, 1'b0, 1'b0);
      #1 chk("plan_youngest", 64'(fwd_rs1_data), 64'h3);
      rf_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      rf_ready = 1'b0;

      // Non-writing beats are accepted but not stored
      fwd_rs1_addr = 0; fwd_rs2_addr = 3;
      beat(1'b1, 0, 32'hdeadbeef, 1'b1, 1'b1);
      step();
      beat(1'b1, 3, 32'h33, 1'b0, 1'b0);
      step();
      beat(1'b0, '0, '0, 1'b0, 1'b0);
      step();

      // Flush overrides a push
      for (int i = 1; i <= 3; i++) begin
         beat(1'b1, REG_AW'(i + 8), 32'h900 + 32'(i), 1'b0, 1'b1);
         step();
      end
      flush = 1'b1;
      beat(1'b1, 12, 32'hc00, 1'b0, 1'b1);
      step();
      flush = 1'b0;
      beat(1'b0, '0, '0, 1'b0, 1'b0);
      step();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         beat(($urandom_range(0, 3) != 0), REG_AW'($urandom_range(0, 7)),
              $urandom, $urandom_range(0, 1) == 1, ($urandom_range(0, 7) != 0));
         rf_ready     = ($urandom_range(0, 2) == 0);
         flush        = ($urandom_range(0, 39) == 0);
         fwd_rs1_addr = REG_AW'($urandom_range(0, 7));
         fwd_rs2_addr = REG_AW'($urandom_range(0, 7));
         step();
      end
      flush = 1'b0;

      // Reset mid-drain
      rf_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         beat(1'b1, REG_AW'(i + 16), 32'ha00 + 32'(i), 1'b1, 1'b1);
         step();
      end
      beat(1'b0, '0, '0, 1'b0, 1'b0);
      rf_ready = 1'b1;
      step();
      #2 rst_n = 1'b0;
      q.delete();
      #1 check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
